// File: rtl/mux4_rr.sv
// rtl/mux4_rr.sv - four-to-one round-robin arbitrating mux with registered output and source tag
module mux4_rr #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel,
    input  logic           out_ready
);

    logic [1:0]   r_ptr;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [1:0]   r_out_sel;

    logic         w_found;
    logic [1:0]   w_gnt;
    logic [1:0]   w_cand;
    logic         w_free;
    logic         w_accept;

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_free   = ~r_out_valid | out_ready;
    // Gating with rst_n keeps in_ready low for the whole time reset is held.
    assign w_accept = rst_n & w_found & w_free;
    assign in_ready = w_accept ? (4'b0001 << w_gnt) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
        end else if (w_accept) begin
            r_ptr       <= w_gnt + 2'd1;
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt*W +: W];
            r_out_sel   <= w_gnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4_rr.sv
// tb/tb_mux4_rr.sv - directed bench for mux4_rr
module tb_mux4_rr;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    mux4_rr #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        // reset with random inputs
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = $urandom;
        out_ready = 1'b1;
        #2;
        chk_out("rst0", 1'b0, 8'h00, 2'd0);
        chk("rst0_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 4'($urandom);
        in_data  = $urandom;
        step();
        chk_out("rst1", 1'b0, 8'h00, 2'd0);
        chk("rst1_in_ready", 32'(in_ready), 32'h0);

        // release with only channel 2 valid
        in_valid  = 4'b0100;
        in_data   = 32'h005A_0000;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("first_in_ready", 32'(in_ready), 32'b0100);
        step();
        chk_out("first", 1'b1, 8'h5A, 2'd2);

        // ptr=3: channels 1 and 3 valid, 3 first then 1
        in_valid  = 4'b1010;
        in_data   = 32'h2300_2100;
        out_ready = 1'b1;
        #1;
        chk("wrap_in_ready3", 32'(in_ready), 32'b1000);
        step();
        chk_out("wrap3", 1'b1, 8'h23, 2'd3);
        in_valid = 4'b0010;
        #1;
        chk("wrap_in_ready1", 32'(in_ready), 32'b0010);
        step();
        chk_out("wrap1", 1'b1, 8'h21, 2'd1);
        in_valid = 4'b0000;
        step();
        chk_out("drain", 1'b0, 8'h21, 2'd1);

        // back-pressure: ptr=2, fill with 0xAA from channel 0
        in_valid  = 4'b0001;
        in_data   = 32'h0000_00AA;
        out_ready = 1'b0;
        step();
        chk_out("bp_fill", 1'b1, 8'hAA, 2'd0);
        in_valid = 4'b0010;
        in_data  = 32'h0000_B100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step();
            chk_out("bp_hold", 1'b1, 8'hAA, 2'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'b0010);
        step();
        chk_out("bp_release", 1'b1, 8'hB1, 2'd1);

        // drain and fill in the same edge from channel 0 (ptr=2)
        in_valid = 4'b0001;
        in_data  = 32'h0000_00C0;
        #1;
        chk("df_in_ready", 32'(in_ready), 32'b0001);
        step();
        chk_out("df", 1'b1, 8'hC0, 2'd0);

        // single beat from channel 3 moves ptr to 0
        in_valid = 4'b1000;
        in_data  = 32'h3300_0000;
        step();
        chk_out("ch3", 1'b1, 8'h33, 2'd3);

        // full round-robin with all channels valid
        in_valid = 4'hF;
        in_data  = 32'h1312_1110;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
            step();
            chk_out("rr", 1'b1, 8'h10 + 8'(i % 4), 2'(i % 4));
        end

        // reset in the middle of traffic
        in_valid = 4'($urandom) | 4'b0001;
        in_data  = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mrst", 1'b0, 8'h00, 2'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("mrst_hold_in_ready", 32'(in_ready), 32'h0);
        chk_out("mrst_hold", 1'b0, 8'h00, 2'd0);
        in_valid = 4'hF;
        in_data  = 32'h1312_1110;
        rst_n    = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        step();
        chk_out("post_rst", 1'b1, 8'h10, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
